// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC types: router port directions and the
//               border-sink per-port framing state.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int SINK_STATE_W = 2;
    localparam int PORT_DIR_W   = 3;

    // Router port directions
    typedef enum logic [PORT_DIR_W-1:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } e_port;

    // Hermes framing position of a border port: header, size, payload
    typedef enum logic [SINK_STATE_W-1:0] {
        HDR  = 2'd0,
        SIZE = 2'd1,
        PAY  = 2'd2
    } e_sink_state;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/noc_border_sink_port.sv
`default_nettype none
// ============================================================================
// Module      : noc_border_sink_port
// Description : Framing tracker for one terminated border port. Follows the
//               Hermes header/size/payload sequence and flags header and
//               flit accepts; flit contents are otherwise discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_border_sink_port
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [FLIT_WIDTH-1:0] data,
    input  logic                  valid,
    input  logic                  credit,
    output logic                  hdr_acc,
    output logic                  flit_acc,
    output logic                  busy
);

    e_sink_state           state;
    e_sink_state           next_state;
    logic [FLIT_WIDTH-1:0] remaining;
    logic                  accept;

    // A flit is only taken while credit is advertised
    assign accept = valid & credit;

    // State register; reset always returns to header position
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= HDR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: advance framing on each accepted flit
    always_comb begin
        next_state = state;
        if (accept) begin
            case (state)
                HDR:     next_state = SIZE;
                SIZE:    next_state = (data == '0) ? HDR : PAY;
                PAY:     next_state = (remaining == FLIT_WIDTH'(1)) ? HDR : PAY;
                default: next_state = HDR;
            endcase
        end
    end

    // Payload countdown: loaded from the size flit, decremented per payload flit
    always_ff @(posedge clock) begin
        if (reset) begin
            remaining <= '0;
        end else if (accept) begin
            if (state == SIZE) begin
                remaining <= data;
            end else if (state == PAY) begin
                remaining <= remaining - FLIT_WIDTH'(1);
            end
        end
    end

    // Outputs: accept strobes and mid-packet indication
    always_comb begin
        hdr_acc  = accept && (state == HDR);
        flit_acc = accept;
        busy     = (state != HDR);
    end

endmodule : noc_border_sink_port
`default_nettype wire

// File: rtl/noc_border_sink.sv
`default_nettype none
// ============================================================================
// Module      : noc_border_sink
// Description : Terminates unconnected mesh-border router ports. Grants
//               credit unconditionally, tracks packet framing per port,
//               discards flits and counts dropped packets/flits.
//               Optional macro BORDER_SINK_IRQ_EN enables a sticky drop IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_border_sink
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int NUM_PORTS  = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int PORT_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS*FLIT_WIDTH-1:0] data_i,
    input  logic [NUM_PORTS-1:0]            rx_i,
    output logic [NUM_PORTS-1:0]            credit_o,
    output logic [NUM_PORTS*FLIT_WIDTH-1:0] data_o,
    output logic [NUM_PORTS-1:0]            tx_o,
    output logic [NUM_PORTS-1:0]            clock_tx_o,
    input  logic                            clear_i,
    output logic [NUM_PORTS-1:0]            busy_o,
    output logic [CNT_WIDTH-1:0]            pkt_count_o,
    output logic [CNT_WIDTH-1:0]            flit_count_o,
    output logic [FLIT_WIDTH-1:0]           last_hdr_o,
    output logic [PORT_IDX_W-1:0]           last_port_o,
    output logic                            irq_o
);

    localparam int INC_W = $clog2(NUM_PORTS + 1);
    localparam int SUM_W = ((CNT_WIDTH > INC_W) ? CNT_WIDTH : INC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

    logic [NUM_PORTS-1:0]  hdr_acc;
    logic [NUM_PORTS-1:0]  flit_acc;
    logic [NUM_PORTS-1:0]  credit;
    logic [INC_W-1:0]      hcount;
    logic [INC_W-1:0]      fcount;
    logic                  hdr_found;
    logic [PORT_IDX_W-1:0] sel_port;
    logic [FLIT_WIDTH-1:0] sel_hdr;
    logic [SUM_W-1:0]      pkt_sum;
    logic [SUM_W-1:0]      flit_sum;
    logic [CNT_WIDTH-1:0]  pkt_next;
    logic [CNT_WIDTH-1:0]  flit_next;
    logic [CNT_WIDTH-1:0]  pkt_count;
    logic [CNT_WIDTH-1:0]  flit_count;
    logic [FLIT_WIDTH-1:0] last_hdr;
    logic [PORT_IDX_W-1:0] last_port;

    // Nothing is ever driven back into the router
    assign data_o     = '0;
    assign tx_o       = '0;
    assign clock_tx_o = '0;

    // Credit comes up one cycle after reset releases and stays up
    always_ff @(posedge clock) begin
        if (reset) begin
            credit <= '0;
        end else begin
            credit <= '1;
        end
    end

    assign credit_o = credit;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            noc_border_sink_port #(
                .FLIT_WIDTH (FLIT_WIDTH)
            ) u_port (
                .clock    (clock),
                .reset    (reset),
                .data     (data_i[p*FLIT_WIDTH +: FLIT_WIDTH]),
                .valid    (rx_i[p]),
                .credit   (credit[p]),
                .hdr_acc  (hdr_acc[p]),
                .flit_acc (flit_acc[p]),
                .busy     (busy_o[p])
            );
        end
    endgenerate

    // Popcount accepts; scan downward so the lowest header port wins
    always_comb begin
        hcount    = '0;
        fcount    = '0;
        hdr_found = 1'b0;
        sel_port  = '0;
        sel_hdr   = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            hcount = hcount + INC_W'(hdr_acc[p]);
            fcount = fcount + INC_W'(flit_acc[p]);
            if (hdr_acc[p]) begin
                hdr_found = 1'b1;
                sel_port  = PORT_IDX_W'(p);
                sel_hdr   = data_i[p*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    // Saturating increments, computed one bit wider to detect overflow
    always_comb begin
        pkt_sum   = SUM_W'(pkt_count) + SUM_W'(hcount);
        flit_sum  = SUM_W'(flit_count) + SUM_W'(fcount);
        pkt_next  = (pkt_sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : pkt_sum[CNT_WIDTH-1:0];
        flit_next = (flit_sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : flit_sum[CNT_WIDTH-1:0];
    end

    // Statistics registers; clear overrides same-cycle updates
    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            pkt_count  <= '0;
            flit_count <= '0;
            last_hdr   <= '0;
            last_port  <= '0;
        end else begin
            pkt_count  <= pkt_next;
            flit_count <= flit_next;
            if (hdr_found) begin
                last_hdr  <= sel_hdr;
                last_port <= sel_port;
            end
        end
    end

    assign pkt_count_o  = pkt_count;
    assign flit_count_o = flit_count;
    assign last_hdr_o   = last_hdr;
    assign last_port_o  = last_port;

`ifdef BORDER_SINK_IRQ_EN
    logic irq;

    // Sticky drop interrupt, raised by any header accept
    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            irq <= 1'b0;
        end else if (hdr_found) begin
            irq <= 1'b1;
        end
    end

    assign irq_o = irq;
`else
    assign irq_o = 1'b0;
`endif

endmodule : noc_border_sink
`default_nettype wire

// File: tb/tb_noc_border_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_border_sink
// Description : Directed self-checking bench for noc_border_sink
//               (8 ports, 32-bit flits, 4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_border_sink;

    localparam int FW  = 32;
    localparam int NP  = 8;
    localparam int CW  = 4;
    localparam int PIW = 3;

`ifdef BORDER_SINK_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic [NP*FW-1:0] data_i;
    logic [NP-1:0]    rx_i;
    logic [NP-1:0]    credit_o;
    logic [NP*FW-1:0] data_o;
    logic [NP-1:0]    tx_o;
    logic [NP-1:0]    clock_tx_o;
    logic             clear_i;
    logic [NP-1:0]    busy_o;
    logic [CW-1:0]    pkt_count_o;
    logic [CW-1:0]    flit_count_o;
    logic [FW-1:0]    last_hdr_o;
    logic [PIW-1:0]   last_port_o;
    logic             irq_o;

    int checks = 0;
    int passes = 0;

    noc_border_sink #(
        .FLIT_WIDTH (FW),
        .NUM_PORTS  (NP),
        .CNT_WIDTH  (CW),
        .PORT_IDX_W (PIW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_i       (data_i),
        .rx_i         (rx_i),
        .credit_o     (credit_o),
        .data_o       (data_o),
        .tx_o         (tx_o),
        .clock_tx_o   (clock_tx_o),
        .clear_i      (clear_i),
        .busy_o       (busy_o),
        .pkt_count_o  (pkt_count_o),
        .flit_count_o (flit_count_o),
        .last_hdr_o   (last_hdr_o),
        .last_port_o  (last_port_o),
        .irq_o        (irq_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one flit on port p for exactly one cycle
    task automatic send(input int p, input logic [FW-1:0] v);
        rx_i              = '0;
        data_i            = '0;
        rx_i[p]           = 1'b1;
        data_i[p*FW +: FW] = v;
        tick();
        rx_i   = '0;
        data_i = '0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        rx_i    = '0;
        data_i  = '0;
        clear_i = 1'b0;

        // 1: reset state
        tick();
        check("rst_credit", credit_o, 0);
        tick();
        tick();
        check("rst_credit3", credit_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_pkt", pkt_count_o, 0);
        check("rst_flit", flit_count_o, 0);
        check("rst_hdr", last_hdr_o, 0);
        check("rst_port", last_port_o, 0);
        check("rst_irq", irq_o, 0);
        check("const_out", {data_o, tx_o, clock_tx_o} == '0, 1);
        reset = 1'b0;
        tick();
        check("credit_up", credit_o, 8'hFF);

        // 2: single packet on port 2 (hdr, size 3, 3 payload)
        send(2, 32'h0000_0101);
        check("t2_busy_mid", busy_o[2], 1);
        check("t2_irq", irq_o, IRQ_EXP);
        send(2, 32'd3);
        send(2, 32'h11);
        send(2, 32'h22);
        check("t2_busy_pay", busy_o[2], 1);
        send(2, 32'h33);
        check("t2_pkt", pkt_count_o, 1);
        check("t2_flit", flit_count_o, 5);
        check("t2_hdr", last_hdr_o, 32'h0101);
        check("t2_port", last_port_o, 2);
        check("t2_busy_end", busy_o[2], 0);
        check("t2_irq_hold", irq_o, IRQ_EXP);
        do_clear();
        check("t2_clr_pkt", pkt_count_o, 0);
        check("t2_clr_irq", irq_o, 0);

        // 3: simultaneous headers on ports 1 and 5
        rx_i           = 8'b0010_0010;
        data_i[1*FW +: FW] = 32'hA;
        data_i[5*FW +: FW] = 32'hB;
        tick();
        rx_i   = '0;
        data_i = '0;
        check("t3_pkt", pkt_count_o, 2);
        check("t3_flit", flit_count_o, 2);
        check("t3_hdr", last_hdr_o, 32'hA);
        check("t3_port", last_port_o, 1);
        check("t3_busy", busy_o, 8'b0010_0010);
        rx_i = 8'b0010_0010;
        tick();
        rx_i = '0;
        check("t3_busy_end", busy_o, 0);
        check("t3_flit2", flit_count_o, 4);
        do_clear();

        // 4: saturation with 20 zero-size packets on port 0
        for (int i = 0; i < 20; i++) begin
            send(0, 32'h100 + i);
            send(0, 32'd0);
        end
        check("t4_pkt_sat", pkt_count_o, 15);
        check("t4_flit_sat", flit_count_o, 15);
        check("t4_hdr", last_hdr_o, 32'h113);
        clear_i = 1'b1;
        send(0, 32'h55);
        clear_i = 1'b0;
        check("t4_clr_pkt", pkt_count_o, 0);
        check("t4_clr_flit", flit_count_o, 0);
        check("t4_clr_hdr", last_hdr_o, 0);
        check("t4_clr_irq", irq_o, 0);
        check("t4_busy_kept", busy_o[0], 1);
        send(0, 32'd0);
        check("t4_pkt_after", pkt_count_o, 0);
        check("t4_flit_after", flit_count_o, 1);
        do_clear();

        // 5: reset in the middle of a packet on port 3
        send(3, 32'h33);
        send(3, 32'd4);
        send(3, 32'h1);
        check("t5_busy_mid", busy_o[3], 1);
        reset = 1'b1;
        tick();
        check("t5_rst_busy", busy_o[3], 0);
        check("t5_rst_credit", credit_o, 0);
        reset = 1'b0;
        tick();
        send(3, 32'h77);
        check("t5_pkt", pkt_count_o, 1);
        check("t5_hdr", last_hdr_o, 32'h77);
        check("t5_port", last_port_o, 3);
        check("t5_irq", irq_o, IRQ_EXP);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_noc_border_sink
`default_nettype wire
